// File: rtl/cache_axi_bridge_if.sv
`default_nettype none
// ============================================================================
//  Module      : cache_axi_bridge_if
//  Description : Cache-side line request port plus the five AXI master
//                channels of the cache-to-AXI bridge, bundled in one interface.
//  Revision    : 1.0
// ============================================================================
interface cache_axi_bridge_if;
    // cache side
    logic        mem_req;
    logic        mem_wen;
    logic        mem_awvalid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_wlast;
    logic        mem_addr_ok;
    logic        mem_data_ok;
    logic [31:0] mem_rdata;
    // AXI read address
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    // AXI read data
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    // AXI write address
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready;
    // AXI write data
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    // AXI write response
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    // bridge side
    modport master (
        input  mem_req, mem_wen, mem_awvalid, mem_addr, mem_wdata, mem_wlast,
        output mem_addr_ok, mem_data_ok, mem_rdata,
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    // cache + memory environment side
    modport slave (
        output mem_req, mem_wen, mem_awvalid, mem_addr, mem_wdata, mem_wlast,
        input  mem_addr_ok, mem_data_ok, mem_rdata,
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );
endinterface
`default_nettype wire

// File: rtl/cache_axi_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : cache_axi_bridge
//  Description : Converts cache line refill / write-back requests into single
//                INCR AXI bursts, one transaction outstanding at a time.
//  Revision    : 1.0
// ============================================================================
module cache_axi_bridge #(
    parameter int         LINE_WORD = 8,
    parameter logic [3:0] AXI_ID    = 4'd1
) (
    input  wire logic             clk,
    input  wire logic             rst,
    cache_axi_bridge_if.master    bus_io
);

    localparam int              CNT_W     = (LINE_WORD > 1) ? $clog2(LINE_WORD) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(LINE_WORD - 1);
    localparam logic [7:0]      BURST_LEN = 8'(LINE_WORD - 1);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        RD_ADDR    = 3'd1,
        RD_DATA    = 3'd2,
        WR_COLLECT = 3'd3,
        WR_ADDR    = 3'd4,
        WR_DATA    = 3'd5,
        WR_RESP    = 3'd6
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        addr_q, addr_d;
    logic [CNT_W-1:0]   wcnt_q, wcnt_d;
    logic [CNT_W-1:0]   bcnt_q, bcnt_d;
    logic [31:0]        line_q [LINE_WORD];

    // State, captured line address and beat counters
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wcnt_q  <= '0;
            bcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wcnt_q  <= wcnt_d;
            bcnt_q  <= bcnt_d;
        end
    end

    // Line buffer filled during write-back collection; contents need no reset
    always_ff @(posedge clk) begin
        if (state_q == WR_COLLECT) begin
            line_q[wcnt_q] <= bus_io.mem_wdata;
        end
    end

    // Next-state and output decode; all handshakes held low while in reset
    always_comb begin
        state_d            = state_q;
        addr_d             = addr_q;
        wcnt_d             = wcnt_q;
        bcnt_d             = bcnt_q;

        bus_io.mem_addr_ok = 1'b0;
        bus_io.mem_data_ok = 1'b0;
        bus_io.mem_rdata   = '0;

        bus_io.arid        = AXI_ID;
        bus_io.araddr      = addr_q;
        bus_io.arlen       = BURST_LEN;
        bus_io.arsize      = 3'b010;
        bus_io.arburst     = 2'b01;
        bus_io.arvalid     = 1'b0;
        bus_io.rready      = 1'b0;

        bus_io.awid        = AXI_ID;
        bus_io.awaddr      = addr_q;
        bus_io.awlen       = BURST_LEN;
        bus_io.awsize      = 3'b010;
        bus_io.awburst     = 2'b01;
        bus_io.awvalid     = 1'b0;

        bus_io.wdata       = line_q[bcnt_q];
        bus_io.wstrb       = 4'hF;
        bus_io.wlast       = 1'b0;
        bus_io.wvalid      = 1'b0;
        bus_io.bready      = 1'b0;

        if (!rst) begin
            case (state_q)
                IDLE: begin
                    bus_io.mem_addr_ok = bus_io.mem_req;
                    if (bus_io.mem_req) begin
                        addr_d  = {bus_io.mem_addr[31:5], 5'b0};
                        state_d = bus_io.mem_wen ? WR_COLLECT : RD_ADDR;
                    end
                end
                RD_ADDR: begin
                    bus_io.arvalid = 1'b1;
                    if (bus_io.arready) state_d = RD_DATA;
                end
                RD_DATA: begin
                    // Beats forwarded with no added latency; rresp is not inspected
                    bus_io.rready      = 1'b1;
                    bus_io.mem_data_ok = bus_io.rvalid;
                    bus_io.mem_rdata   = bus_io.rdata;
                    if (bus_io.rvalid && bus_io.rlast) state_d = IDLE;
                end
                WR_COLLECT: begin
                    bus_io.mem_data_ok = 1'b1;
                    if (wcnt_q == LAST_IDX) begin
                        wcnt_d  = '0;
                        state_d = WR_ADDR;
                    end else begin
                        wcnt_d  = wcnt_q + 1'b1;
                    end
                end
                WR_ADDR: begin
                    bus_io.awvalid = 1'b1;
                    if (bus_io.awready) state_d = WR_DATA;
                end
                WR_DATA: begin
                    bus_io.wvalid = 1'b1;
                    bus_io.wlast  = (bcnt_q == LAST_IDX);
                    if (bus_io.wready) begin
                        if (bcnt_q == LAST_IDX) begin
                            bcnt_d  = '0;
                            state_d = WR_RESP;
                        end else begin
                            bcnt_d  = bcnt_q + 1'b1;
                        end
                    end
                end
                WR_RESP: begin
                    // Holding off new requests here orders a following refill behind the write
                    bus_io.bready = 1'b1;
                    if (bus_io.bvalid) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cache_axi_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cache_axi_bridge
//  Description : Self-checking bench for cache_axi_bridge; a scoreboard queue
//                holds expected words pushed at stimulus time.
//  Revision    : 1.0
// ============================================================================
module tb_cache_axi_bridge;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cache_axi_bridge_if bus ();

    cache_axi_bridge #(.LINE_WORD(8), .AXI_ID(4'd1)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus)
    );

    int          n_pass  = 0;
    int          n_total = 0;
    logic [31:0] exp_q[$];
    logic [31:0] obs_q[$];

    function automatic logic [48:0] snap(input bit is_wr);
        if (is_wr) return {bus.awid, bus.awaddr, bus.awlen, bus.awsize, bus.awburst};
        return {bus.arid, bus.araddr, bus.arlen, bus.arsize, bus.arburst};
    endfunction

    function automatic logic vld(input bit is_wr);
        return is_wr ? bus.awvalid : bus.arvalid;
    endfunction

    function automatic logic [7:0] ctrl();
        return {bus.arvalid, bus.awvalid, bus.wvalid, bus.wlast,
                bus.rready, bus.bready, bus.mem_addr_ok, bus.mem_data_ok};
    endfunction

    task automatic init_inputs();
        bus.mem_req = 0; bus.mem_wen = 0; bus.mem_awvalid = 0; bus.mem_addr = '0;
        bus.mem_wdata = '0; bus.mem_wlast = 0;
        bus.arready = 0; bus.rid = 4'd1; bus.rdata = '0; bus.rresp = '0;
        bus.rlast = 0; bus.rvalid = 0; bus.awready = 0; bus.wready = 0;
        bus.bid = 4'd1; bus.bresp = '0; bus.bvalid = 0;
    endtask

    // Hold mem_req until mem_addr_ok is seen, then release after the accepting edge
    task automatic issue_req(input logic wen, input logic [31:0] addr, output int waited);
        bus.mem_req = 1'b1; bus.mem_wen = wen; bus.mem_awvalid = wen; bus.mem_addr = addr;
        waited = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.mem_addr_ok === 1'b1) begin waited = i; break; end
            @(posedge clk); #1;
        end
        if (waited >= 0) begin @(posedge clk); #1; end
        bus.mem_req = 1'b0;
    endtask

    // Wait for AR/AW valid, stall ready for 'stall' cycles, then handshake
    task automatic addr_hs(input bit is_wr, input int stall, output logic [48:0] fields,
                           output bit ok, output bit stable);
        ok = 0; stable = 1; fields = '0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (vld(is_wr) === 1'b1) begin ok = 1; break; end
            @(posedge clk); #1;
        end
        if (!ok) return;
        fields = snap(is_wr);
        repeat (stall) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (vld(is_wr) !== 1'b1 || snap(is_wr) !== fields) stable = 0;
        end
        @(posedge clk); #1;
        if (is_wr) bus.awready = 1'b1; else bus.arready = 1'b1;
        @(negedge clk);
        if (vld(is_wr) !== 1'b1 || snap(is_wr) !== fields) stable = 0;
        @(posedge clk); #1;
        bus.awready = 1'b0; bus.arready = 1'b0;
    endtask

    // Drive nbeats R beats (optionally gapped); expected pushed on drive, observed on mem_data_ok
    task automatic r_beats(input logic [31:0] base, input int nbeats, input bit gapped,
                           output int pulses, output int mirror_err);
        int beat;
        beat = 0; pulses = 0; mirror_err = 0;
        for (int cyc = 0; cyc < 100 && beat < nbeats; cyc++) begin
            bus.rvalid = !(gapped && (cyc % 2 == 1));
            bus.rdata  = base + beat;
            bus.rlast  = (beat == 7);
            bus.rresp  = 2'(cyc % 4);
            if (bus.rvalid) exp_q.push_back(bus.rdata);
            @(negedge clk);
            if (bus.mem_data_ok === 1'b1) begin obs_q.push_back(bus.mem_rdata); pulses++; end
            if (bus.mem_data_ok !== bus.rvalid || bus.rready !== 1'b1) mirror_err++;
            if (bus.rvalid) beat++;
            @(posedge clk); #1;
        end
        bus.rvalid = 0; bus.rlast = 0;
    endtask

    // Supply write-back words for a fixed window and count mem_data_ok pulses
    task automatic wb_collect(input logic [31:0] base, output int pulses, output bit consec);
        int first, last, k;
        first = -1; last = -1; k = 0; pulses = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            bus.mem_wdata = base + k;
            @(negedge clk);
            if (bus.mem_data_ok === 1'b1) begin
                exp_q.push_back(bus.mem_wdata);
                if (first < 0) first = cyc;
                last = cyc; pulses++; k++;
            end
            @(posedge clk); #1;
        end
        consec = (pulses > 0) && (last - first + 1 == pulses);
    endtask

    // Accept W beats, optionally stalling wready 3 cycles at beat stall_beat
    task automatic w_beats(input int stall_beat, output int err, output bit ok);
        int beats, stall_left;
        logic [31:0] held;
        bit held_v;
        beats = 0; stall_left = 3; held = '0; held_v = 0; err = 0;
        for (int cyc = 0; cyc < 60 && beats < 8; cyc++) begin
            bus.wready = !(beats == stall_beat && stall_left > 0);
            if (!bus.wready) stall_left--;
            @(negedge clk);
            if (bus.wvalid === 1'b1) begin
                if (bus.wready) begin
                    obs_q.push_back(bus.wdata);
                    if (bus.wlast !== (beats == 7) || bus.wstrb !== 4'hF) err++;
                    if (held_v && bus.wdata !== held) err++;
                    held_v = 0; beats++;
                end else begin
                    if (held_v && bus.wdata !== held) err++;
                    held = bus.wdata; held_v = 1;
                end
            end
            @(posedge clk); #1;
        end
        bus.wready = 0;
        ok = (beats == 8);
    endtask

    // Delay bvalid by 'delay' cycles, counting any mem_addr_ok seen meanwhile
    task automatic b_resp(input int delay, output int early_ok, output int bready_err);
        early_ok = 0; bready_err = 0; bus.bvalid = 0;
        for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            if (bus.bready !== 1'b1) bready_err++;
            if (bus.mem_addr_ok === 1'b1) early_ok++;
            @(posedge clk); #1;
        end
        bus.bvalid = 1'b1; bus.bresp = 2'b00;
        @(negedge clk);
        if (bus.bready !== 1'b1) bready_err++;
        if (bus.mem_addr_ok === 1'b1) early_ok++;
        @(posedge clk); #1;
        bus.bvalid = 1'b0;
    endtask

    task automatic test_reset();
        init_inputs();
        rst = 1'b1;
        bus.mem_req = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        n_total++;
        if (ctrl() !== 8'h00) $display("FAIL reset_ctrl: got %b expected %b", ctrl(), 8'h00); else n_pass++;
        n_total++;
        if (bus.mem_rdata !== 32'h0 || bus.araddr !== 32'h0)
            $display("FAIL reset_data: rdata %h araddr %h expected 0", bus.mem_rdata, bus.araddr);
        else n_pass++;
        @(posedge clk); #1;
        bus.mem_req = 1'b0; rst = 1'b0;
        @(negedge clk);
        n_total++;
        if (ctrl() !== 8'h00) $display("FAIL idle_ctrl: got %b expected %b", ctrl(), 8'h00); else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic refill(input logic [31:0] addr, input logic [31:0] line, input logic [31:0] base,
                          input int stall, input bit gapped, input string tag);
        int w, p, me;
        bit ok, st;
        logic [48:0] f;
        logic [31:0] e, o;
        issue_req(1'b0, addr, w);
        n_total++;
        if (w !== 0) $display("FAIL %s_addr_ok: waited %0d expected 0", tag, w); else n_pass++;
        addr_hs(1'b0, stall, f, ok, st);
        n_total++;
        if (f !== {4'd1, line, 8'd7, 3'b010, 2'b01} || !ok)
            $display("FAIL %s_ar_fields: got %h expected %h", tag, f, {4'd1, line, 8'd7, 3'b010, 2'b01});
        else n_pass++;
        n_total++;
        if (!st) $display("FAIL %s_ar_stable: got unstable expected stable", tag); else n_pass++;
        r_beats(base, 8, gapped, p, me);
        n_total++;
        if (p !== 8 || me !== 0) $display("FAIL %s_r_pulses: pulses %0d mirror_err %0d expected 8/0", tag, p, me); else n_pass++;
        n_total++;
        if (obs_q.size() !== exp_q.size()) $display("FAIL %s_r_count: got %0d expected %0d", tag, obs_q.size(), exp_q.size()); else n_pass++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_total++;
            if (o !== e) $display("FAIL %s_rdata: got %h expected %h", tag, o, e); else n_pass++;
        end
        exp_q.delete(); obs_q.delete();
        @(negedge clk);
        n_total++;
        if ({bus.rready, bus.mem_data_ok, bus.arvalid} !== 3'b000)
            $display("FAIL %s_idle_after_rlast: got %b expected 000", tag, {bus.rready, bus.mem_data_ok, bus.arvalid});
        else n_pass++;
        @(posedge clk); #1;
    endtask

    // Write-back up to and including the W burst; response handled by caller
    task automatic writeback(input logic [31:0] addr, input logic [31:0] base, input int stall,
                             input string tag);
        int w, p, err;
        bit ok, st, c;
        logic [48:0] f;
        logic [31:0] e, o;
        issue_req(1'b1, addr, w);
        n_total++;
        if (w !== 0) $display("FAIL %s_addr_ok: waited %0d expected 0", tag, w); else n_pass++;
        wb_collect(base, p, c);
        n_total++;
        if (p !== 8 || !c) $display("FAIL %s_collect: pulses %0d consecutive %0d expected 8/1", tag, p, c); else n_pass++;
        addr_hs(1'b1, stall, f, ok, st);
        n_total++;
        if (f !== {4'd1, addr, 8'd7, 3'b010, 2'b01} || !ok || !st)
            $display("FAIL %s_aw: got %h stable %0d expected %h stable 1", tag, f, st, {4'd1, addr, 8'd7, 3'b010, 2'b01});
        else n_pass++;
        w_beats(stall > 0 ? 2 : -1, err, ok);
        n_total++;
        if (!ok || err !== 0) $display("FAIL %s_w_beats: done %0d errors %0d expected 1/0", tag, ok, err); else n_pass++;
        n_total++;
        if (obs_q.size() !== exp_q.size()) $display("FAIL %s_w_count: got %0d expected %0d", tag, obs_q.size(), exp_q.size()); else n_pass++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_total++;
            if (o !== e) $display("FAIL %s_wdata: got %h expected %h", tag, o, e); else n_pass++;
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_refill();
        refill(32'h1FC0_0044, 32'h1FC0_0040, 32'h0, 0, 1'b0, "refill");
    endtask

    task automatic test_writeback();
        int eo, be;
        writeback(32'h0000_1000, 32'hA0, 0, "wb");
        b_resp(0, eo, be);
        n_total++;
        if (be !== 0) $display("FAIL wb_bready: errors %0d expected 0", be); else n_pass++;
        @(negedge clk);
        n_total++;
        if ({bus.bready, bus.wvalid} !== 2'b00) $display("FAIL wb_idle: got %b expected 00", {bus.bready, bus.wvalid}); else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        int eo, be;
        refill(32'h0000_2044, 32'h0000_2040, 32'h200, 3, 1'b0, "bp_rd");
        writeback(32'h0000_3000, 32'hC0, 3, "bp_wr");
        b_resp(2, eo, be);
        n_total++;
        if (be !== 0) $display("FAIL bp_bready: errors %0d expected 0", be); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int eo, be;
        writeback(32'h0000_4000, 32'hD0, 0, "b2b_wr");
        bus.mem_req = 1'b1; bus.mem_wen = 1'b0; bus.mem_awvalid = 1'b0; bus.mem_addr = 32'h0000_5000;
        b_resp(5, eo, be);
        n_total++;
        if (eo !== 0 || be !== 0) $display("FAIL b2b_held_off: early_ok %0d bready_err %0d expected 0/0", eo, be); else n_pass++;
        @(negedge clk);
        n_total++;
        if (bus.mem_addr_ok !== 1'b1) $display("FAIL b2b_addr_ok_after_b: got %b expected 1", bus.mem_addr_ok); else n_pass++;
        @(posedge clk); #1;
        bus.mem_req = 1'b0;
        begin
            int p, me;
            bit ok, st;
            logic [48:0] f;
            addr_hs(1'b0, 0, f, ok, st);
            n_total++;
            if (f !== {4'd1, 32'h0000_5000, 8'd7, 3'b010, 2'b01} || !ok)
                $display("FAIL b2b_ar: got %h expected %h", f, {4'd1, 32'h0000_5000, 8'd7, 3'b010, 2'b01});
            else n_pass++;
            r_beats(32'h500, 8, 1'b0, p, me);
            n_total++;
            if (p !== 8 || me !== 0 || obs_q !== exp_q)
                $display("FAIL b2b_rdata: pulses %0d mirror_err %0d expected 8/0 with matching data", p, me);
            else n_pass++;
            exp_q.delete(); obs_q.delete();
        end
    endtask

    task automatic test_reset_mid_read();
        int w, p, me;
        bit ok, st;
        logic [48:0] f;
        issue_req(1'b0, 32'h0000_6000, w);
        addr_hs(1'b0, 0, f, ok, st);
        r_beats(32'h600, 4, 1'b0, p, me);
        n_total++;
        if (p !== 4 || me !== 0 || obs_q !== exp_q)
            $display("FAIL rst_mid_beats: pulses %0d mirror_err %0d expected 4/0 with matching data", p, me);
        else n_pass++;
        exp_q.delete(); obs_q.delete();
        rst = 1'b1; bus.rvalid = 1'b1; bus.rdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_total++;
        if (ctrl() !== 8'h00 || bus.mem_rdata !== 32'h0 || bus.araddr !== 32'h0)
            $display("FAIL rst_mid_outputs: ctrl %b rdata %h araddr %h expected 0", ctrl(), bus.mem_rdata, bus.araddr);
        else n_pass++;
        @(posedge clk); #1;
        bus.rvalid = 1'b0;
        refill(32'h0000_7010, 32'h0000_7000, 32'h700, 0, 1'b0, "rst_fresh");
    endtask

    task automatic test_gapped();
        refill(32'h0000_8000, 32'h0000_8000, 32'h800, 0, 1'b1, "gapped");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_refill();
        test_writeback();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_read();
        test_gapped();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cache_axi_bridge.md
CACHE_AXI_BRIDGE -- requirements
Module: cache_axi_bridge

Interface
REQ-001 The module SHALL have parameter LINE_WORD, default 8, meaning words per cache line and AXI burst beats.
REQ-002 The module SHALL have parameter AXI_ID, default 4'd1, meaning the ID driven on arid and awid.
REQ-003 The module SHALL have one clock and a synchronous, active-high reset, on the ports listed in REQ-004 and REQ-005.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  reset.
REQ-006 mem_req  input  1  line transfer request from the cache.
REQ-007 mem_wen  input  1  1 = line write-back, 0 = line refill, sampled with mem_req.
REQ-008 mem_awvalid  input  1  write-back qualifier; ignored, mem_wen decides.
REQ-009 mem_addr  input  32  physical line address.
REQ-010 mem_wdata  input  32  write-back word, valid in cycles where mem_data_ok=1.
REQ-011 mem_wlast  input  1  cache-side last flag; not used; the bridge counts beats itself.
REQ-012 mem_addr_ok  output  1  request accepted.
REQ-013 mem_data_ok  output  1  one beat transferred.
REQ-014 mem_rdata  output  32  refill word.
REQ-015 AXI master ports:
- read address: arid 4, araddr 32, arlen 8, arsize 3, arburst 2, arvalid out; arready in.
- read data: rid 4, rdata 32, rresp 2, rlast 1, rvalid in; rready out.
- write address: awid 4, awaddr 32, awlen 8, awsize 3, awburst 2, awvalid out; awready in.
- write data: wdata 32, wstrb 4, wlast 1, wvalid out; wready in.
- write response: bid 4, bresp 2, bvalid in; bready out.

Function
REQ-016 The FSM SHALL have states IDLE, RD_ADDR, RD_DATA, WR_COLLECT, WR_ADDR, WR_DATA, WR_RESP.
REQ-017 In IDLE with mem_req=1, the bridge SHALL do all of the following:
- assert mem_addr_ok combinationally for that one cycle;
- capture {mem_addr[31:5],5'b0} and mem_wen;
- go to WR_COLLECT if mem_wen=1, else to RD_ADDR.
REQ-018 mem_addr_ok SHALL be 0 in every state except IDLE; requests arriving outside IDLE are held off, not dropped.
REQ-019 RD_ADDR SHALL drive the AR channel:
- arvalid=1, araddr=captured address, arlen=LINE_WORD-1, arsize=3'b010, arburst=2'b01 (INCR);
- all fields held stable until the cycle arvalid&arready, then go to RD_DATA.
REQ-020 In RD_DATA the bridge SHALL behave as follows:
- rready=1;
- each cycle with rvalid=1: mem_data_ok=1 and mem_rdata=rdata, same cycle, zero added latency;
- on rvalid&rlast, return to IDLE next cycle.
REQ-021 rresp SHALL be ignored; beats are forwarded regardless.
REQ-022 In WR_COLLECT the bridge SHALL do all of the following:
- assert mem_data_ok=1 for exactly LINE_WORD consecutive cycles;
- store mem_wdata into line buffer entry wcnt, wcnt counting 0..LINE_WORD-1;
- after the entry LINE_WORD-1 cycle, go to WR_ADDR.
REQ-023 WR_ADDR SHALL drive the AW channel with the same field rules as REQ-019 (awvalid=1, awaddr=captured address), then go to WR_DATA on awvalid&awready.
REQ-024 WR_DATA SHALL drive the W channel:
- wvalid=1, wdata=buffer[bcnt], wstrb=4'hF;
- wlast=1 only when bcnt=LINE_WORD-1;
- bcnt increments on wvalid&wready;
- the last accepted beat moves to WR_RESP.
REQ-025 WR_RESP SHALL assert bready=1 and return to IDLE on bvalid; no new request is accepted before bvalid, so a refill following a write-back is ordered behind it.
REQ-026 mem_data_ok SHALL be 0 in IDLE, RD_ADDR, WR_ADDR, WR_DATA and WR_RESP.
REQ-027 mem_rdata SHALL be 0 outside RD_DATA.
REQ-028 Bit widths:
- wcnt and bcnt SHALL be $clog2(LINE_WORD) bits, wrapping to 0 on state exit;
- unused upper bits of arlen/awlen SHALL be 0.
REQ-029 Only one outstanding AXI transaction SHALL exist at any time.

Reset
REQ-030 When rst=1 at a clock edge, the bridge SHALL enter IDLE from any state, including mid-burst, and SHALL clear wcnt, bcnt and the captured address.
REQ-031 While in reset and after reset, the bridge SHALL drive arvalid, awvalid, wvalid, wlast, rready, bready, mem_addr_ok and mem_data_ok at 0.
REQ-032 The line buffer SHALL not be reset.

Verification
REQ-033 Refill: mem_req=1, mem_wen=0, mem_addr=0x1FC0_0044 -> mem_addr_ok pulse; araddr=0x1FC0_0040, arlen=7; 8 R beats 0..7 -> mem_data_ok on each, rdata passed through unchanged; IDLE after rlast.
REQ-034 Write-back: mem_wen=1, addr 0x0000_1000, wdata 0xA0..0xA7 -> mem_data_ok 8 cycles; then AW addr 0x0000_1000, W beats 0xA0..0xA7, wlast on 0xA7 only; IDLE after bvalid.
REQ-035 Backpressure: arready, awready and wready low for 3 cycles each -> all fields held stable; no duplicate or skipped beat.
REQ-036 Write-back then refill: mem_req held during WR_RESP with bvalid delayed 5 cycles -> mem_addr_ok only in the cycle after bvalid returns the FSM to IDLE.
REQ-037 Reset mid-RD_DATA after 4 beats -> all outputs 0 next cycle; a fresh request completes normally.
REQ-038 Gapped R beats with rvalid toggling -> mem_data_ok exactly mirrors rvalid, 8 pulses total.
